// File: rtl/wb_pkg.sv
// wb_pkg: shared types and constants for the writeback arbiter slice.
//   DATA_W / ADDR_W : register width and register address width
//   PC_REG_ADDR     : r15 is PC-mapped and read-only, so writes to it are dropped
//   wb_req_t        : one pending register write (destination + value)
//   wb_src_t        : which producer is selected for the write port this cycle
package wb_pkg;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 4;
  localparam logic [ADDR_W-1:0] PC_REG_ADDR = 4'd15;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_req_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_MEM,
    SRC_FIFO,
    SRC_ALU
  } wb_src_t;

endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: synchronous FIFO of wb_req_t holding ALU results that lost
// arbitration to the load unit.
//   clk, reset    : clock, synchronous active-high reset (empties the FIFO)
//   push/push_req : write one entry at the tail
//   pop/head      : head entry (valid when count != 0), removed on pop
//   count         : current occupancy, 0..DEPTH
//   entry_valid   : per-slot valid, slot 0 = oldest (head), slot DEPTH-1 = youngest
//   entry_addr    : per-slot destination register, same ordering
//   entry_data    : per-slot data, same ordering (only with WB_BYPASS_EN)
// Optional macro: WB_BYPASS_EN adds the entry_data scan output.
// The caller guarantees no push when full and no pop when empty.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            push,
  input  wb_req_t                         push_req,
  input  logic                            pop,
  output wb_req_t                         head,
  output logic [$clog2(DEPTH):0]          count,
  output logic [DEPTH-1:0]                entry_valid,
  output logic [DEPTH-1:0][ADDR_W-1:0]    entry_addr
`ifdef WB_BYPASS_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0]    entry_data
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_req_t           mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;

  // Pointers are plain binary counters; DEPTH is a power of two so they
  // wrap naturally. Resetting them is what discards the stored entries.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; validity is tracked purely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_req;
    end
  end

  assign head = mem[rd_ptr];

  // Present entries in age order (oldest first) so consumers can pick the
  // youngest match by scanning upward without knowing the pointers.
  always_comb begin
    entry_valid = '0;
    entry_addr  = '0;
`ifdef WB_BYPASS_EN
    entry_data  = '0;
`endif
    for (int k = 0; k < DEPTH; k++) begin
      entry_valid[k] = (CNT_W'(k) < count);
      entry_addr[k]  = mem[rd_ptr + PTR_W'(k)].addr;
`ifdef WB_BYPASS_EN
      entry_data[k]  = mem[rd_ptr + PTR_W'(k)].data;
`endif
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: writeback stage in front of the 16-entry register file. Merges
// the ALU (backpressured) and the load unit (never stalled, always wins) onto
// one registered write port. ALU results that lose are queued in wb_fifo.
//   clk, reset                       : clock, synchronous active-high reset
//   alu_valid/alu_addr/alu_data      : ALU result; accepted when alu_ready
//   alu_ready                        : FIFO has room (registered count only)
//   mem_valid/mem_addr/mem_data      : load result, always accepted
//   wr_en/wr_addr/wr_data            : registered regfile write port
//   busy                             : bit i set while a write to ri is pending
//   fifo_cnt                         : ALU holding-FIFO occupancy
//   byp_addr/byp_hit/byp_data        : combinational forwarding (WB_BYPASS_EN)
// Optional macro: WB_BYPASS_EN adds the bypass ports and their lookup logic.
// DATA_W/ADDR_W must match wb_pkg, since the queued request type comes from it.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int DATA_W     = wb_pkg::DATA_W,
  parameter int ADDR_W     = wb_pkg::ADDR_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          alu_valid,
  input  logic [ADDR_W-1:0]             alu_addr,
  input  logic [DATA_W-1:0]             alu_data,
  output logic                          alu_ready,
  input  logic                          mem_valid,
  input  logic [ADDR_W-1:0]             mem_addr,
  input  logic [DATA_W-1:0]             mem_data,
  output logic                          wr_en,
  output logic [ADDR_W-1:0]             wr_addr,
  output logic [DATA_W-1:0]             wr_data,
  output logic [15:0]                   busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
`ifdef WB_BYPASS_EN
  ,
  input  logic [ADDR_W-1:0]             byp_addr,
  output logic                          byp_hit,
  output logic [DATA_W-1:0]             byp_data
`endif
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  wb_src_t                              src;
  wb_req_t                              sel_req;
  wb_req_t                              alu_req;
  wb_req_t                              fifo_head;
  logic                                 alu_accept;
  logic                                 fifo_push;
  logic                                 fifo_pop;
  logic                                 fifo_empty;
  logic [FIFO_DEPTH-1:0]                entry_valid;
  logic [FIFO_DEPTH-1:0][ADDR_W-1:0]    entry_addr;
`ifdef WB_BYPASS_EN
  logic [FIFO_DEPTH-1:0][DATA_W-1:0]    entry_data;
`endif

  // Ready looks only at the registered count: a pop this cycle does not
  // make room for a push this cycle, keeping ready off the selection path.
  assign alu_ready  = !reset && (fifo_cnt < CNT_W'(FIFO_DEPTH));
  assign alu_accept = alu_valid && alu_ready;
  assign fifo_empty = (fifo_cnt == '0);
  assign alu_req    = '{addr: alu_addr, data: alu_data};

  // Source priority: load, then oldest queued ALU result, then cut-through.
  // Whenever something else owns the port, an accepted ALU result queues
  // behind the existing entries so ALU order is never broken.
  always_comb begin
    src       = SRC_NONE;
    sel_req   = '0;
    fifo_push = 1'b0;
    fifo_pop  = 1'b0;
    if (mem_valid) begin
      src       = SRC_MEM;
      sel_req   = '{addr: mem_addr, data: mem_data};
      fifo_push = alu_accept;
    end else if (!fifo_empty) begin
      src       = SRC_FIFO;
      sel_req   = fifo_head;
      fifo_pop  = 1'b1;
      fifo_push = alu_accept;
    end else if (alu_accept) begin
      src       = SRC_ALU;
      sel_req   = alu_req;
    end
  end

  wb_fifo #(
    .DEPTH       (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_req    (alu_req),
    .pop         (fifo_pop),
    .head        (fifo_head),
    .count       (fifo_cnt),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
`ifdef WB_BYPASS_EN
    ,
    .entry_data  (entry_data)
`endif
  );

  // Output register. A selected r15 write still consumes its slot but is
  // not enabled, so the PC-mapped register is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= (src != SRC_NONE) && (sel_req.addr != PC_REG_ADDR);
      if (src != SRC_NONE) begin
        wr_addr <= sel_req.addr;
        wr_data <= sel_req.data;
      end
    end
  end

  // Pending-write scoreboard. Queued r15 entries never become writes, so
  // bit 15 is forced low.
  always_comb begin
    busy = '0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (entry_valid[k]) begin
        busy[entry_addr[k]] = 1'b1;
      end
    end
    if (wr_en) begin
      busy[wr_addr] = 1'b1;
    end
    busy[PC_REG_ADDR] = 1'b0;
  end

`ifdef WB_BYPASS_EN
  // Forwarding lookup. The output register is older than anything in the
  // FIFO, and FIFO slots are scanned oldest to youngest, so the last match
  // written wins and is the youngest value.
  always_comb begin
    byp_hit  = 1'b0;
    byp_data = '0;
    if (wr_en && (wr_addr == byp_addr)) begin
      byp_hit  = 1'b1;
      byp_data = wr_data;
    end
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (entry_valid[k] && (entry_addr[k] == byp_addr)) begin
        byp_hit  = 1'b1;
        byp_data = entry_data[k];
      end
    end
    if (byp_addr == PC_REG_ADDR) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed self-checking bench for wb_arbiter. Inputs change
// 1 time unit after the rising edge; registered outputs are checked there
// too, and alu_ready is checked after the inputs settle within the cycle.
// Optional macro: WB_BYPASS_EN enables the bypass port checks.
module tb_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        alu_valid;
  logic [3:0]  alu_addr;
  logic [15:0] alu_data;
  logic        alu_ready;
  logic        mem_valid;
  logic [3:0]  mem_addr;
  logic [15:0] mem_data;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic [15:0] busy;
  logic [2:0]  fifo_cnt;
`ifdef WB_BYPASS_EN
  logic [3:0]  byp_addr;
  logic        byp_hit;
  logic [15:0] byp_data;
`endif

  int checks   = 0;
  int failures = 0;

  bit exp_rdy [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
  int exp_cnt [8] = '{1, 2, 3, 4, 4, 4, 3, 3};

  always #5 clk = ~clk;

  wb_arbiter #(
    .DATA_W     (16),
    .ADDR_W     (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .alu_valid  (alu_valid),
    .alu_addr   (alu_addr),
    .alu_data   (alu_data),
    .alu_ready  (alu_ready),
    .mem_valid  (mem_valid),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .busy       (busy),
    .fifo_cnt   (fifo_cnt)
`ifdef WB_BYPASS_EN
    ,
    .byp_addr   (byp_addr),
    .byp_hit    (byp_hit),
    .byp_data   (byp_data)
`endif
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic mv, input logic [3:0] ma, input logic [15:0] md,
                               input logic av, input logic [3:0] aa, input logic [15:0] ad);
    mem_valid = mv;
    mem_addr  = ma;
    mem_data  = md;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
  endtask

  task automatic applyIdle();
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 16'h0000);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [3:0] a, input logic [15:0] d);
    checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'(en));
    if (en) begin
      checkOutput({tag, ".wr_addr"}, 32'(wr_addr), 32'(a));
      checkOutput({tag, ".wr_data"}, 32'(wr_data), 32'(d));
    end
  endtask

  initial begin
    int k;
    reset = 1'b1;
`ifdef WB_BYPASS_EN
    byp_addr = 4'd0;
`endif
    applyIdle();

    // Reset state
    tick();
    tick();
    checkOutput("rst.wr_en", 32'(wr_en), 32'd0);
    checkOutput("rst.busy", 32'(busy), 32'h0000);
    checkOutput("rst.fifo_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("rst.alu_ready", 32'(alu_ready), 32'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_rst.alu_ready", 32'(alu_ready), 32'd1);

    // Cut-through: one-cycle latency
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd3, 16'h1234);
    tick();
    applyIdle();
    checkWrite("cut", 1'b1, 4'd3, 16'h1234);
    checkOutput("cut.busy", 32'(busy), 32'h0008);
    checkOutput("cut.fifo_cnt", 32'(fifo_cnt), 32'd0);
    tick();
    checkWrite("cut.idle", 1'b0, 4'd0, 16'h0000);
    checkOutput("cut.idle.busy", 32'(busy), 32'h0000);

    // Load priority with ALU results queued in order
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd5, 16'hAAAA, 1'b1, 4'(i + 1), 16'(16'h1111 * (i + 1)));
      #1;
      checkOutput($sformatf("prio%0d.alu_ready", i), 32'(alu_ready), 32'd1);
      tick();
      checkWrite($sformatf("prio%0d", i), 1'b1, 4'd5, 16'hAAAA);
      checkOutput($sformatf("prio%0d.fifo_cnt", i), 32'(fifo_cnt), 32'(i + 1));
    end
    checkOutput("prio.busy", 32'(busy), 32'h002E);
    applyIdle();
    for (int i = 0; i < 3; i++) begin
      tick();
      checkWrite($sformatf("drain%0d", i), 1'b1, 4'(i + 1), 16'(16'h1111 * (i + 1)));
      checkOutput($sformatf("drain%0d.fifo_cnt", i), 32'(fifo_cnt), 32'(2 - i));
      if (i == 0) checkOutput("drain0.busy", 32'(busy), 32'h000E);
    end
    tick();
    checkWrite("drain.idle", 1'b0, 4'd0, 16'h0000);

    // r15 absorption
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd15, 16'hBEEF);
    #1;
    checkOutput("r15.alu_ready", 32'(alu_ready), 32'd1);
    tick();
    checkWrite("r15", 1'b0, 4'd0, 16'h0000);
    checkOutput("r15.busy", 32'(busy), 32'h0000);
    applyStimulus(1'b0, 4'd0, 16'h0000, 1'b1, 4'd4, 16'h4444);
    tick();
    applyIdle();
    checkWrite("r4", 1'b1, 4'd4, 16'h4444);
    checkOutput("r4.busy", 32'(busy), 32'h0010);
    tick();

    // Full FIFO: 6 load cycles with continuous ALU traffic
    k = 0;
    for (int c = 0; c < 8; c++) begin
      applyStimulus(c < 6, 4'd6, 16'h5555, 1'b1, 4'(8 + k), 16'(16'hC000 + k));
      #1;
      checkOutput($sformatf("full%0d.alu_ready", c), 32'(alu_ready), 32'(exp_rdy[c]));
      tick();
      if (exp_rdy[c]) k++;
      if (c < 6)
        checkWrite($sformatf("full%0d", c), 1'b1, 4'd6, 16'h5555);
      else
        checkWrite($sformatf("full%0d", c), 1'b1, 4'(8 + c - 6), 16'(16'hC000 + c - 6));
      checkOutput($sformatf("full%0d.fifo_cnt", c), 32'(fifo_cnt), 32'(exp_cnt[c]));
    end
    applyIdle();
    for (int j = 0; j < 3; j++) begin
      tick();
      checkWrite($sformatf("fulldrain%0d", j), 1'b1, 4'(10 + j), 16'(16'hC002 + j));
    end
    tick();
    checkWrite("fulldrain.idle", 1'b0, 4'd0, 16'h0000);
    checkOutput("fulldrain.fifo_cnt", 32'(fifo_cnt), 32'd0);

`ifdef WB_BYPASS_EN
    // Bypass: two queued writes to r6, load to r7 in the output register
    applyStimulus(1'b1, 4'd7, 16'h7777, 1'b1, 4'd6, 16'h0001);
    tick();
    applyStimulus(1'b1, 4'd7, 16'h7777, 1'b1, 4'd6, 16'h0002);
    tick();
    applyIdle();
    byp_addr = 4'd6;
    #1;
    checkOutput("byp6.hit", 32'(byp_hit), 32'd1);
    checkOutput("byp6.data", 32'(byp_data), 32'h0002);
    byp_addr = 4'd7;
    #1;
    checkOutput("byp7.hit", 32'(byp_hit), 32'd1);
    checkOutput("byp7.data", 32'(byp_data), 32'h7777);
    byp_addr = 4'd15;
    #1;
    checkOutput("byp15.hit", 32'(byp_hit), 32'd0);
    byp_addr = 4'd2;
    #1;
    checkOutput("byp2.hit", 32'(byp_hit), 32'd0);
    tick();
    checkWrite("bypdrain0", 1'b1, 4'd6, 16'h0001);
    tick();
    checkWrite("bypdrain1", 1'b1, 4'd6, 16'h0002);
    tick();
    checkWrite("bypdrain.idle", 1'b0, 4'd0, 16'h0000);
`endif

    // Reset mid-operation discards queued and pending writes
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 4'd9, 16'h9999, 1'b1, 4'(i + 1), 16'(16'hD000 + i));
      tick();
    end
    checkOutput("midrst.pre_cnt", 32'(fifo_cnt), 32'd3);
    applyIdle();
    reset = 1'b1;
    #1;
    checkOutput("midrst.alu_ready", 32'(alu_ready), 32'd0);
    tick();
    reset = 1'b0;
    checkOutput("midrst.wr_en", 32'(wr_en), 32'd0);
    checkOutput("midrst.fifo_cnt", 32'(fifo_cnt), 32'd0);
    checkOutput("midrst.busy", 32'(busy), 32'h0000);
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput($sformatf("midrst.quiet%0d", i), 32'(wr_en), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
